// File: rtl/mult_sequencer.sv
// Sequences one multi-cycle multiply: it latches the operands, pulses the multiplier,
// waits a bounded number of cycles for the result, then issues a single register write-back.
module mult_sequencer #(
  parameter int WORD       = 64,
  parameter int MAX_CYCLES = 70   // legal range 2..127, so the 7-bit counter never wraps
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mult_req,
  input  logic [4:0]      dest_reg,
  input  logic [WORD-1:0] operand_a,
  input  logic [WORD-1:0] operand_b,
  input  logic            mult_done,
  input  logic [WORD-1:0] mult_product,
  output logic            mult_start,
  output logic [WORD-1:0] mult_a,
  output logic [WORD-1:0] mult_b,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_reg,
  output logic [WORD-1:0] wb_data,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  localparam logic [6:0] CNT_LAST = 7'(MAX_CYCLES - 1);

  state_t          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [WORD-1:0] a_q, a_d;
  logic [WORD-1:0] b_q, b_d;
  logic [4:0]      reg_q, reg_d;
  logic [WORD-1:0] data_q, data_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    reg_d   = reg_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mult_req) begin
          a_d     = operand_a;
          b_d     = operand_b;
          reg_d   = dest_reg;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = 7'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (mult_done) begin
          data_d  = mult_product;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      a_q     <= '0;
      b_q     <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Control outputs are gated by reset so they read 0 even before the first reset edge.
  assign mult_start  = !reset && (state_q == S_START);
  assign wb_valid    = !reset && (state_q == S_WB);
  assign busy        = !reset && (state_q != S_IDLE);
  assign stall       = !reset && (((state_q == S_IDLE) && mult_req) ||
                                  (state_q == S_START) || (state_q == S_WAIT));
  assign timeout_err = !reset && err_q;

  assign mult_a  = a_q;
  assign mult_b  = b_q;
  assign wb_reg  = reg_q;
  assign wb_data = data_q;

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter WORD, default 64, datapath width of operands and product.
REQ-002 Parameter MAX_CYCLES, default 70, maximum WAIT cycles before timeout; legal range 2..127.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mult_req  input  1  current instruction is a multiply (from control decode).
REQ-006 dest_reg  input  5  destination register (rd) of the multiply.
REQ-007 operand_a  input  WORD  read_data1 of the multiply.
REQ-008 operand_b  input  WORD  read_data2 of the multiply.
REQ-009 mult_done  input  1  multiplier result valid, one-cycle pulse.
REQ-010 mult_product  input  WORD  multiplier result, valid when mult_done=1.
REQ-011 mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-012 mult_a  output  WORD  latched operand A to the multiplier.
REQ-013 mult_b  output  WORD  latched operand B to the multiplier.
REQ-014 stall  output  1  holds PC/fetch while a multiply is in flight.
REQ-015 wb_valid  output  1  one-cycle register-file write request.
REQ-016 wb_reg  output  5  write-back destination register.
REQ-017 wb_data  output  WORD  write-back data (latched product).
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 timeout_err  output  1  sticky timeout flag.

Function
REQ-020 The block SHALL implement states IDLE, START, WAIT, WB, ERR, with IDLE as the reset state.
REQ-021 IDLE: if mult_req=1, the block SHALL latch operand_a, operand_b, dest_reg into mult_a, mult_b, wb_reg and enter START; otherwise it SHALL remain in IDLE.
REQ-022 START: mult_start SHALL be 1 for exactly this cycle; the cycle counter SHALL be cleared to 0; the next state SHALL be WAIT.
REQ-023 WAIT: if mult_done=1, the block SHALL latch mult_product into wb_data and enter WB; otherwise it SHALL increment the counter, entering ERR when the counter equals MAX_CYCLES-1.
REQ-024 When mult_done=1 coincides with counter=MAX_CYCLES-1, the block SHALL take mult_done (enter WB, no error).
REQ-025 WB: wb_valid SHALL be 1 for exactly this cycle, with wb_reg and wb_data stable; the next state SHALL be IDLE.
REQ-026 ERR: timeout_err SHALL be set; wb_valid SHALL be 0; the next state SHALL be IDLE.
REQ-027 stall SHALL equal (state==IDLE && mult_req) || state==START || state==WAIT (combinational), and SHALL be 0 in WB and ERR so the instruction retires.
REQ-028 mult_req SHALL be ignored in START, WAIT, WB and ERR.
REQ-029 mult_done SHALL be ignored in IDLE, START, WB and ERR.
REQ-030 mult_a, mult_b, wb_reg and wb_data SHALL change only on the latch events defined in REQ-021 and REQ-023.
REQ-031 Latency from the IDLE cycle with mult_req=1 to wb_valid SHALL be N+2 cycles when mult_done arrives on the N-th WAIT cycle (N≥1).
REQ-032 The counter SHALL be 7 bits wide and SHALL never wrap.

Reset
REQ-033 While reset=1, the block SHALL force state=IDLE and counter=0, and drive mult_start=0, stall=0, wb_valid=0, busy=0 and timeout_err=0.
REQ-034 While reset=1, mult_a, mult_b, wb_data and wb_reg SHALL be set to 0.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL abort the operation; a later mult_done SHALL produce no write-back.
REQ-036 timeout_err SHALL clear only on reset.

Verification
REQ-037 Basic multiply: with operand_a=3, operand_b=5, dest_reg=9 and mult_req=1, and mult_done (product 15) on WAIT cycle 4, the bench SHALL check mult_start for one cycle, stall high for 6 cycles, then wb_valid=1, wb_reg=9, wb_data=15 for one cycle.
REQ-038 Immediate done: with mult_done on WAIT cycle 1, the bench SHALL check wb_valid 3 cycles after the request cycle and stall low during WB.
REQ-039 Timeout: with MAX_CYCLES=4 and mult_done never asserted, the bench SHALL check that the block enters ERR after 4 WAIT cycles, timeout_err stays 1, wb_valid stays 0, and the block returns to IDLE.
REQ-040 Boundary: with MAX_CYCLES=4 and mult_done on WAIT cycle 4, the bench SHALL check WB with no error.
REQ-041 Reset mid-WAIT: with reset on WAIT cycle 2 and mult_done one cycle later, the bench SHALL check all outputs 0, no wb_valid, and state IDLE.
REQ-042 Back-to-back: with mult_req held high across WB followed by a new multiply (operand_a=-2, operand_b=7, product -14), the bench SHALL check the second sequence starts in the IDLE cycle after WB and write-back carries 0xFFFF_FFFF_FFFF_FFF2.
